// File: rtl/score_keeper.sv
// Match rules core: goal counting, win detection and timed serve sequencing.
// Optional SCORE_WIN_BY_TWO_EN: winner must also lead by two (reaching 31 always wins).
module score_keeper #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GOAL1,
  input  logic       GOAL2,
  input  logic       NEW_GAME,
  output logic [4:0] Score1,
  output logic [4:0] Score2,
  output logic       WIN1,
  output logic       WIN2,
  output logic       SERVE_EN,
  output logic       SERVE_DIR,
  output logic       IN_PLAY
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE_WAIT, S_PLAY, S_GAME_OVER} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [5:0]       WIN_S    = 6'(WIN_SCORE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       s1_q, s1_d, s2_q, s2_d;
  logic             w1_q, w1_d, w2_q, w2_d;
  logic             en_q, en_d, dir_q, dir_d, play_q, play_d;
  logic             ng_prev_q;

  logic             rise;
  logic [4:0]       s1_inc, s2_inc;
  logic             win1, win2;

  assign rise   = NEW_GAME & ~ng_prev_q;
  assign s1_inc = (s1_q == 5'd31) ? 5'd31 : s1_q + 5'd1;
  assign s2_inc = (s2_q == 5'd31) ? 5'd31 : s2_q + 5'd1;

`ifdef SCORE_WIN_BY_TWO_EN
  // Reaching 31 ends the match regardless of margin so the score bus cannot overflow.
  assign win1 = (s1_inc == 5'd31) ||
                (({1'b0, s1_inc} >= WIN_S) && ({1'b0, s1_inc} >= {1'b0, s2_q} + 6'd2));
  assign win2 = (s2_inc == 5'd31) ||
                (({1'b0, s2_inc} >= WIN_S) && ({1'b0, s2_inc} >= {1'b0, s1_q} + 6'd2));
`else
  assign win1 = ({1'b0, s1_inc} >= WIN_S);
  assign win2 = ({1'b0, s2_inc} >= WIN_S);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    en_d    = 1'b0;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        s1_d = '0;
        s2_d = '0;
        w1_d = 1'b0;
        w2_d = 1'b0;
        if (rise) begin
          state_d = S_SERVE_WAIT;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end
      end
      S_SERVE_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PLAY: begin
        // Simultaneous goals are treated as a physics glitch and dropped.
        if (GOAL1 && !GOAL2) begin
          s1_d  = s1_inc;
          dir_d = 1'b1;
          if (win1) begin
            w1_d    = 1'b1;
            state_d = S_GAME_OVER;
          end else begin
            state_d = S_SERVE_WAIT;
            cnt_d   = '0;
          end
        end else if (GOAL2 && !GOAL1) begin
          s2_d  = s2_inc;
          dir_d = 1'b0;
          if (win2) begin
            w2_d    = 1'b1;
            state_d = S_GAME_OVER;
          end else begin
            state_d = S_SERVE_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_GAME_OVER: begin
        if (rise) begin
          s1_d    = '0;
          s2_d    = '0;
          w1_d    = 1'b0;
          w2_d    = 1'b0;
          dir_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SERVE_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    play_d = (state_d == S_PLAY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      w1_q      <= 1'b0;
      w2_q      <= 1'b0;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
      play_q    <= 1'b0;
      ng_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      play_q    <= play_d;
      ng_prev_q <= NEW_GAME;
    end
  end

  assign Score1    = s1_q;
  assign Score2    = s2_q;
  assign WIN1      = w1_q;
  assign WIN2      = w2_q;
  assign SERVE_EN  = en_q;
  assign SERVE_DIR = dir_q;
  assign IN_PLAY   = play_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Game-rules core that produces the Score1/Score2/WIN1/WIN2 bus consumed by the seven-segment/LED score display. Counts points from single-cycle goal strobes issued by the ball/collision logic, detects match end, and sequences serves with a timed delay. Sits between ball physics (goal events, serve release) and the score display.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..31 (5-bit score bus).
SERVE_DELAY, 50000000, CLK cycles from entry to SERVE_WAIT until the SERVE_EN pulse (1 s at 50 MHz); must be >=1.
CNT_W, 26, width of the serve delay counter; must hold SERVE_DELAY-1.

Ports:
CLK  input  1  system clock (Clock_50).
RST  input  1  synchronous, active-high reset.
GOAL1  input  1  single-cycle strobe: player 1 scored.
GOAL2  input  1  single-cycle strobe: player 2 scored.
NEW_GAME  input  1  level from debounced push-button; rising edge starts or restarts a match.
Score1  output  5  player 1 score, 0..31.
Score2  output  5  player 2 score, 0..31.
WIN1  output  1  player 1 has won; held until next match start.
WIN2  output  1  player 2 has won; held until next match start.
SERVE_EN  output  1  single-cycle pulse: release ball.
SERVE_DIR  output  1  direction of released ball: 0 = toward player 1, 1 = toward player 2.
IN_PLAY  output  1  high while in PLAY state.

Behaviour:
- All outputs registered. Reset: Score1=Score2=0, WIN1=WIN2=0, SERVE_EN=0, SERVE_DIR=0, IN_PLAY=0, delay counter=0, NEW_GAME edge register=1 (a button held through reset does not start a match), state=IDLE. Reset mid-match aborts immediately at the next edge.
- NEW_GAME edge detect: one register stage; rise = NEW_GAME & ~prev.
- States: IDLE, SERVE_WAIT, PLAY, GAME_OVER.
- IDLE: scores 0. Rise -> SERVE_WAIT, counter cleared, SERVE_DIR=0.
- SERVE_WAIT: counter increments each cycle; when counter == SERVE_DELAY-1: SERVE_EN=1 for exactly one cycle, counter cleared, -> PLAY (IN_PLAY=1 same cycle as SERVE_EN). Goal strobes ignored.
- PLAY: sampled each cycle.
  - GOAL1 only: Score1+1 visible next cycle; SERVE_DIR=1 (serve toward conceding player 2).
  - GOAL2 only: Score2+1 visible next cycle; SERVE_DIR=0.
  - GOAL1 and GOAL2 same cycle: both ignored, remain in PLAY.
  - After a valid goal: if new score >= WIN_SCORE, set that player's WIN in the same cycle the score updates, -> GAME_OVER; else -> SERVE_WAIT, counter cleared.
- GAME_OVER: scores and WIN frozen, goals ignored, IN_PLAY=0. Rise -> scores 0, WIN1=WIN2=0, SERVE_DIR=0, -> SERVE_WAIT.
- Rise in SERVE_WAIT or PLAY: ignored (no mid-match restart; use RST).
- Never both WIN1 and WIN2. Scores saturate at 31, never wrap.

Optional Feature:
Macro SCORE_WIN_BY_TWO_EN.
- Defined: a win also requires lead >= 2 (score >= WIN_SCORE and score - other >= 2). Exception: a score reaching 31 wins regardless of margin, so the 5-bit bus cannot overflow.
- Undefined: first to WIN_SCORE wins, margin ignored.

Test Plan:
1. WIN_SCORE=3, SERVE_DELAY=4: RST, release, NEW_GAME 0->1 -> SERVE_EN one cycle 4 cycles after the edge-detected rise, SERVE_DIR=0, IN_PLAY=1.
2. In PLAY pulse GOAL1 -> Score1=1 next cycle, SERVE_DIR=1, IN_PLAY=0, SERVE_EN pulses again after 4 cycles; GOAL1 during SERVE_WAIT -> Score1 stays 1.
3. GOAL1 and GOAL2 same cycle in PLAY -> scores unchanged, still PLAY; then three GOAL2 rallies -> Score2=3, WIN2=1 on the same cycle, no further SERVE_EN, subsequent goals ignored.
4. GAME_OVER, NEW_GAME rise -> scores 0, WIN2=0, SERVE_EN after 4 cycles; NEW_GAME held high across RST -> stays IDLE until released and re-pressed.
5. SCORE_WIN_BY_TWO_EN, WIN_SCORE=3: reach 2-2, GOAL1 -> 3-2, no WIN; GOAL1 -> 4-2, WIN1=1. Alternating goals from 2-2 up to 30-30, then GOAL2 -> Score2=31, WIN2=1.
6. RST asserted mid-PLAY with Score1=2 -> next cycle all outputs at reset values, state IDLE.
